// File: rtl/mem_req_issue.sv
// Memory-op issue stage between EX and the dcache: issues requests, tracks in-flight ops,
// buffers responses in a 2-deep FIFO with zero-latency bypass, and drops responses owed to flushed ops.
module mem_req_issue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic [3:0]  req_wstrb_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        req_ready_o,
    output logic        data_req_o,
    output logic        data_wr_o,
    output logic [1:0]  data_size_o,
    output logic [3:0]  data_wstrb_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_addr_ok_i,
    input  logic        data_data_ok_i,
    input  logic [31:0] data_rdata_i,
    output logic        resp_valid_o,
    output logic        resp_we_o,
    output logic [31:0] resp_rdata_o,
    input  logic        resp_ready_i,
    input  logic        excep_flush_i,
    output logic [1:0]  cache_rdata_ce_we_o,
    output logic [1:0]  o_dbg_outstanding,
    output logic [1:0]  o_dbg_fifo_cnt,
    output logic [2:0]  o_dbg_discard_cnt
);

    // Handshakes: req is taken when req_valid_i && req_ready_o; the dcache takes a request when
    // data_req_o && data_addr_ok_i; a response is consumed when resp_valid_o && resp_ready_i.
    // rst_n is an active-high reset despite its name.

    logic [1:0]  r_outstanding;
    logic [1:0]  r_fifo_cnt;
    logic [2:0]  r_discard_cnt;
    logic [1:0]  r_tag;
    logic [1:0]  r_fifo_we;
    logic [31:0] r_fifo_data [2];

    logic        w_room;
    logic        w_accept;
    logic        w_discarding;
    logic        w_ok_live;
    logic        w_ok_drop;
    logic        w_fifo_empty;
    logic        w_pop;
    logic        w_bypass_taken;
    logic        w_push;
    logic        w_push_slot;
    logic [1:0]  w_owed;
    logic [2:0]  w_disc_next;
    logic [2:0]  w_disc_delta;

    assign w_room       = ({1'b0, r_outstanding} + {1'b0, r_fifo_cnt}) < 3'd2;
    assign data_req_o   = ~rst_n & req_valid_i & ~excep_flush_i & w_room;
    assign req_ready_o  = data_req_o & data_addr_ok_i;
    assign w_accept     = req_ready_o;

    assign data_wr_o    = req_we_i;
    assign data_size_o  = req_size_i;
    assign data_wstrb_o = req_wstrb_i;
    assign data_addr_o  = req_addr_i;
    assign data_wdata_o = req_wdata_i;

    assign w_discarding = (r_discard_cnt != 3'd0);
    assign w_ok_live    = ~rst_n & data_data_ok_i & ~w_discarding;
    assign w_ok_drop    = ~rst_n & data_data_ok_i & w_discarding;
    assign w_fifo_empty = (r_fifo_cnt == 2'd0);

    // Buffered data always leaves first so responses stay in order; the bus bypasses only an empty FIFO.
    assign resp_valid_o = ~rst_n & ~excep_flush_i & (~w_fifo_empty | w_ok_live);
    assign resp_we_o    = w_fifo_empty ? r_tag[0] : r_fifo_we[0];
    assign resp_rdata_o = w_fifo_empty ? data_rdata_i : r_fifo_data[0];

    assign w_pop          = ~w_fifo_empty & resp_valid_o & resp_ready_i;
    assign w_bypass_taken = w_fifo_empty & w_ok_live & resp_ready_i & ~excep_flush_i;
    assign w_push         = w_ok_live & ~w_bypass_taken & ~excep_flush_i;
    assign w_push_slot    = w_pop ? (r_fifo_cnt == 2'd2) : (r_fifo_cnt == 2'd1);

    // Responses still owed after this cycle's data_ok; on a flush they all become discards.
    assign w_owed       = r_outstanding - {1'b0, w_ok_live};
    assign w_disc_next  = r_discard_cnt - {2'b00, w_ok_drop}
                        + (excep_flush_i ? {1'b0, w_owed} : 3'd0);
    assign w_disc_delta = w_disc_next - r_discard_cnt;

    // The tracker code is the net change in pending discards, so a flush folds in a same-cycle drop.
    always_comb begin
        cache_rdata_ce_we_o = 2'b00;
        if (!rst_n) begin
            case (w_disc_delta)
                3'd1:    cache_rdata_ce_we_o = 2'b10;
                3'd2:    cache_rdata_ce_we_o = 2'b11;
                3'd7:    cache_rdata_ce_we_o = 2'b01;
                default: cache_rdata_ce_we_o = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_outstanding  <= 2'd0;
            r_fifo_cnt     <= 2'd0;
            r_discard_cnt  <= 3'd0;
            r_tag          <= 2'b00;
            r_fifo_we      <= 2'b00;
            r_fifo_data[0] <= 32'd0;
            r_fifo_data[1] <= 32'd0;
        end else if (excep_flush_i) begin
            r_outstanding <= 2'd0;
            r_fifo_cnt    <= 2'd0;
            r_tag         <= 2'b00;
            r_discard_cnt <= w_disc_next;
        end else begin
            r_outstanding <= r_outstanding + {1'b0, w_accept} - {1'b0, w_ok_live};
            r_fifo_cnt    <= r_fifo_cnt + {1'b0, w_push} - {1'b0, w_pop};
            r_discard_cnt <= w_disc_next;
            if (w_ok_live) begin
                r_tag[0] <= r_tag[1];
            end
            if (w_accept) begin
                r_tag[w_owed[0]] <= req_we_i;
            end
            if (w_pop) begin
                r_fifo_we[0]   <= r_fifo_we[1];
                r_fifo_data[0] <= r_fifo_data[1];
            end
            if (w_push) begin
                r_fifo_we[w_push_slot]   <= r_tag[0];
                r_fifo_data[w_push_slot] <= data_rdata_i;
            end
        end
    end

    assign o_dbg_outstanding = r_outstanding;
    assign o_dbg_fifo_cnt    = r_fifo_cnt;
    assign o_dbg_discard_cnt = r_discard_cnt;

    // The issue gate is what keeps the FIFO from ever taking a third entry.
    a_no_fifo_overflow: assert property (@(posedge clk) disable iff (rst_n)
        !(w_push && !w_pop && r_fifo_cnt == 2'd2));

endmodule
